// File: rtl/btn_count_ctrl.sv
// btn_count_ctrl: synchronises and debounces two raw push buttons (count-up,
// count-down). Each accepted press becomes a single-cycle en pulse, with the
// direction presented on up, to drive a 4-bit up/down counter.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-high reset
//   btn_up   - raw count-up button (asynchronous, bouncy)
//   btn_down - raw count-down button (asynchronous, bouncy)
//   en       - registered one-cycle pulse per accepted press
//   up       - registered direction, 1 = up, 0 = down; held between presses
//   up_db    - debounced level of btn_up
//   down_db  - debounced level of btn_down
module btn_count_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  output logic en,
  output logic up,
  output logic up_db,
  output logic down_db
);

  localparam int unsigned TIMER_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned NB      = 2;
  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    HIGH    = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  // Bit 0 = up button, bit 1 = down button throughout.
  logic [NB-1:0] raw;
  logic [NB-1:0] meta_q;
  logic [NB-1:0] sync_q;
  logic [NB-1:0] press;
  logic [NB-1:0] db_d;
  logic [NB-1:0] db_q;
  logic          en_d;
  logic          up_d;

  assign raw = {btn_down, btn_up};

  // Two-flop synchroniser per button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
    end
  end

  // Per-button debounce FSM.
  for (genvar i = 0; i < NB; i++) begin : g_btn
    state_t             state_q;
    state_t             state_d;
    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] timer_d;
    logic               hit;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
        timer_q <= '0;
      end else begin
        state_q <= state_d;
        timer_q <= timer_d;
      end
    end

    always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      hit     = 1'b0;
      case (state_q)
        IDLE: begin
          if (sync_q[i]) begin
            state_d = WAIT_HI;
            timer_d = '0;
          end
        end
        WAIT_HI: begin
          if (!sync_q[i]) begin
            state_d = IDLE;
          end else if (timer_q == LAST) begin
            state_d = HIGH;
            hit     = 1'b1;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
        HIGH: begin
          if (!sync_q[i]) begin
            state_d = WAIT_LO;
            timer_d = '0;
          end
        end
        WAIT_LO: begin
          if (sync_q[i]) begin
            state_d = HIGH;
          end else if (timer_q == LAST) begin
            state_d = IDLE;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    assign press[i] = hit;
    assign db_d[i]  = (state_d == HIGH) || (state_d == WAIT_LO);
  end

  // A press on exactly one button pulses en; a coincident pair is ambiguous and dropped.
  always_comb begin
    en_d = press[0] ^ press[1];
    up_d = up;
    if (press == 2'b01) begin
      up_d = 1'b1;
    end else if (press == 2'b10) begin
      up_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en   <= 1'b0;
      up   <= 1'b1;
      db_q <= '0;
    end else begin
      en   <= en_d;
      up   <= up_d;
      db_q <= db_d;
    end
  end

  assign up_db   = db_q[0];
  assign down_db = db_q[1];

endmodule

// File: doc/btn_count_ctrl.md
Name: btn_count_ctrl

Overview:
- Upstream control stage for the 4-bit up/down counter (`cnt`).
- Takes two raw, asynchronous push-button inputs (count-up, count-down), synchronises and debounces each, and converts each accepted press into a single-cycle `en` pulse with a matching `up` direction level.
- `en` and `up` drive the counter's `en` and `up` inputs directly, so one physical press moves the count by exactly one.

Parameters:
- DEBOUNCE_CYCLES, 500000, clock cycles a synchronised input must stay stable before a level change is accepted (5 ms at 100 MHz); legal range >= 2.
- TIMER_W, $clog2(DEBOUNCE_CYCLES), width of each debounce timer; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- btn_up  input  1  raw count-up button, asynchronous to clk, bouncy.
- btn_down  input  1  raw count-down button, asynchronous to clk, bouncy.
- en  output  1  registered one-cycle pulse per accepted press; connects to the counter's `en`.
- up  output  1  registered direction: 1 = up, 0 = down; connects to the counter's `up`.
- up_db  output  1  debounced level of btn_up.
- down_db  output  1  debounced level of btn_down.

Behaviour:
- Reset (asynchronous, active-high):
  - Sync flops = 0, both FSMs = IDLE, timers = 0.
  - en = 0, up = 1, up_db = 0, down_db = 0.
  - A button held through reset release must complete a full debounce again.
- Synchroniser:
  - Each button passes through two flops; the FSM sees only the second flop (s).
- Per-button FSM (two identical instances). States are IDLE, WAIT_HI, HIGH, WAIT_LO; db = 1 in HIGH and WAIT_LO.
  - IDLE: s = 1 -> WAIT_HI, timer <= 0.
  - WAIT_HI: s = 0 -> IDLE. Otherwise, if timer == DEBOUNCE_CYCLES-1 -> HIGH (accept press); else timer++.
  - HIGH: s = 0 -> WAIT_LO, timer <= 0.
  - WAIT_LO: s = 1 -> HIGH (no new press). Otherwise, if timer == DEBOUNCE_CYCLES-1 -> IDLE (release accepted); else timer++.
- Latency:
  - Let edge 1 be the first rising edge sampling raw = 1, with raw held stable.
  - The FSM enters HIGH, and en/db rise, after edge DEBOUNCE_CYCLES+3.
  - Release is symmetric: db falls after edge DEBOUNCE_CYCLES+3 counted from the first edge sampling raw = 0.
- Pulse and direction:
  - en is registered and set for exactly one cycle on the edge an FSM goes WAIT_HI -> HIGH.
  - On that same edge, up <= 1 for the up button or 0 for the down button.
  - up holds its value between presses.
  - Holding a button produces no further pulses (no auto-repeat).
  - A bounce shorter than DEBOUNCE_CYCLES returns WAIT_HI to IDLE with no pulse.
- Simultaneous events:
  - Both FSMs entering HIGH on the same edge -> en stays 0 and up is unchanged (ambiguous press rejected).
  - One button already in HIGH/WAIT_LO while the other completes WAIT_HI -> normal pulse for the second button.
- Reset mid-debounce: all state clears immediately; no pulse is emitted for the interrupted press.

Test Plan (DEBOUNCE_CYCLES = 4, 10 ns clock):
- Reset: hold rst for 4 cycles with both buttons high -> en = 0, up = 1, up_db = down_db = 0 throughout; after release, first en exactly 7 edges later.
- Clean up-press: btn_up 0 -> 1 held 20 cycles -> en high exactly 1 cycle, 7 edges after first sample; up = 1; up_db = 1; downstream `cnt` goes 0 -> 1.
- Bounce: btn_up toggles 1,0,1,0 every 2 cycles, then holds 1 -> no en during bouncing; exactly one en after 4 stable synced cycles.
- Down-press: after an up-press, press btn_down cleanly -> one en with up = 0; `cnt` goes 1 -> 0; press again -> `cnt` wraps 0 -> 15.
- Simultaneous: assert btn_up and btn_down on the same edge and hold -> en never asserts, up unchanged; stagger them by 2 cycles -> two separate pulses, final up = later button.
- Reset mid-operation: assert rst 2 cycles into WAIT_HI -> no en; release rst with button still held -> one en 7 edges after release.
